// File: rtl/spi_reg_pkg.sv
// ============================================================================
// Module  : spi_reg_pkg
// Purpose : Shared types and constants for the SPI register controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_reg_pkg;

    typedef enum logic [1:0] {
        CMD   = 2'd0,
        LEN   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
    } cmd_t;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam logic [7:0] BAD_ADDR_BYTE = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ============================================================================
// Module  : spi_reg_bank
// Purpose : Config register storage, write decode and read-back mux with range check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_CFG  = 8,
    parameter int NUM_STAT = 4
) (
    input  logic                  sclk,
    input  logic                  rst_L,
    input  logic                  wr_en,
    input  logic [6:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wr_ok,
    input  logic [6:0]            rd_addr,
    output logic [7:0]            rd_data,
    output logic                  rd_ok,
    input  logic [8*NUM_STAT-1:0] stat,
    output logic [8*NUM_CFG-1:0]  cfg
);

    assign wr_ok = (wr_addr < 7'(NUM_CFG));

    always_ff @(posedge sclk or negedge rst_L) begin
        if (!rst_L) begin
            cfg <= '0;
        end else if (wr_en && wr_ok) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (wr_addr == 7'(k)) begin
                    cfg[8*k +: 8] <= wr_data;
                end
            end
        end
    end

    // Anything outside the cfg and status windows reads back as BAD_ADDR_BYTE.
    always_comb begin
        rd_data = BAD_ADDR_BYTE;
        rd_ok   = 1'b0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (rd_addr == 7'(k)) begin
                rd_data = cfg[8*k +: 8];
                rd_ok   = 1'b1;
            end
        end
        for (int k = 0; k < NUM_STAT; k++) begin
            if (rd_addr == 7'(NUM_CFG + k)) begin
                rd_data = stat[8*k +: 8];
                rd_ok   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
// ============================================================================
// Module  : spi_reg_ctrl
// Purpose : Framed command/register controller behind a byte-level SPI slave.
//           SPI_REG_AUTOINC_EN: address advances after every data byte.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int NUM_CFG  = 8,
    parameter int NUM_STAT = 4
) (
    input  logic                  sclk,
    input  logic                  rst_L,
    input  logic                  ready_in,
    input  logic [7:0]            buffer_in,
    input  logic                  read,
    output logic [7:0]            outbuf,
    input  logic [8*NUM_STAT-1:0] stat,
    output logic [8*NUM_CFG-1:0]  cfg,
    output logic                  wr_stb,
    output logic [6:0]            wr_addr,
    output logic                  busy,
    output logic                  err
);

    state_t     state, state_nxt;
    cmd_t       cmd_in;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] cnt;
    logic       bank_wr_en, wr_ok, rd_ok, load_rd;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    assign cmd_in = cmd_t'(buffer_in);
    assign busy   = (state != CMD);

    always_ff @(posedge sclk or negedge rst_L) begin
        if (!rst_L) state <= CMD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CMD:   if (ready_in) state_nxt = LEN;
            LEN: begin
                if (ready_in) begin
                    if (buffer_in == 8'd0) state_nxt = CMD;
                    else if (rw)           state_nxt = RDATA;
                    else                   state_nxt = WDATA;
                end
            end
            WDATA, RDATA: if (ready_in && cnt == 8'd1) state_nxt = CMD;
            default: state_nxt = CMD;
        endcase
    end

    // Read data is fetched on entry to RDATA and after each read strobe that keeps us there.
    always_comb begin
        bank_wr_en = (state == WDATA) && ready_in;
        load_rd    = (state_nxt == RDATA) && ((state == LEN) || read);
`ifdef SPI_REG_AUTOINC_EN
        rd_addr    = (state == RDATA) ? addr + 7'd1 : addr;
`else
        rd_addr    = addr;
`endif
    end

    always_ff @(posedge sclk or negedge rst_L) begin
        if (!rst_L) begin
            rw      <= 1'b0;
            addr    <= '0;
            cnt     <= '0;
            outbuf  <= SYNC_BYTE;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            err     <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            case (state)
                CMD: begin
                    if (ready_in) begin
                        rw   <= cmd_in.rw;
                        addr <= cmd_in.addr;
                    end
                end
                LEN: if (ready_in) cnt <= buffer_in;
                WDATA: begin
                    if (ready_in) begin
                        cnt <= cnt - 8'd1;
                        if (wr_ok) begin
                            wr_stb  <= 1'b1;
                            wr_addr <= addr;
                        end else begin
                            err <= 1'b1;
                        end
`ifdef SPI_REG_AUTOINC_EN
                        addr <= addr + 7'd1;
`endif
                    end
                end
                RDATA: begin
                    if (ready_in) cnt <= cnt - 8'd1;
`ifdef SPI_REG_AUTOINC_EN
                    if (read) addr <= addr + 7'd1;
`endif
                end
                default: ;
            endcase
            if (load_rd) begin
                outbuf <= rd_data;
                if (!rd_ok) err <= 1'b1;
            end else if (state_nxt != RDATA) begin
                outbuf <= SYNC_BYTE;
            end
        end
    end

    spi_reg_bank #(
        .NUM_CFG  (NUM_CFG),
        .NUM_STAT (NUM_STAT)
    ) u_bank (
        .sclk    (sclk),
        .rst_L   (rst_L),
        .wr_en   (bank_wr_en),
        .wr_addr (addr),
        .wr_data (buffer_in),
        .wr_ok   (wr_ok),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_ok   (rd_ok),
        .stat    (stat),
        .cfg     (cfg)
    );

endmodule

`default_nettype wire
